pe_sequencer: RTL and testbench

- Main control FSM for the single-PE convolution datapath.
- Loads the stride and filter-size config, then issues IFMap/filter reads (put_data/put_filter) while both operands are available.
- Advances filter windows and IFMap rows on the datapath's co_filter/end_of_row flags.
- Drains the 3-stage MAC pipeline, then signals completion. Sits between the top-level host interface and the datapath control inputs.

---
 rtl/pe_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// pe_sequencer: main control FSM for the single-PE convolution datapath.
// Loads stride/filter-size config, issues operand reads while both operands
// are available, steps filter windows and IFMap rows, drains the MAC pipe
// and pulses done.
// Optional build macro: PE_SEQ_STALL_CNT_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
module pe_sequencer #(
   parameter int unsigned ROW_CNT_WIDTH   = 8,
   parameter int unsigned PIPE_DEPTH      = 3,
   parameter int unsigned DRAIN_CNT_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [ROW_CNT_WIDTH-1:0] num_rows,
   input  logic                     av_data,
   input  logic                     av_filter,
   input  logic                     co_filter,
   input  logic                     end_of_row,
   output logic                     ld_stride,
   output logic                     ld_filterSize,
   output logic                     clear_sum,
   output logic                     put_data,
   output logic                     put_filter,
   output logic                     next_filter,
   output logic                     next_row,
   output logic                     store_buffer,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              stall_cycles
);

   localparam int unsigned STALL_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_CFG  = 3'd1,
      S_COMPUTE   = 3'd2,
      S_NEXT_FILT = 3'd3,
      S_NEXT_ROW  = 3'd4,
      S_DRAIN     = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;

   logic [ROW_CNT_WIDTH-1:0]   r_num_rows;
   logic [ROW_CNT_WIDTH-1:0]   r_row_cnt;
   logic [DRAIN_CNT_WIDTH-1:0] r_drain_cnt;

   logic                       w_issue;
   logic                       w_last_row;
   logic                       w_drain_last;
   logic                       w_capture;
   logic                       w_row_inc;
   logic                       w_drain_clr;
   logic                       w_drain_inc;

   logic                       w_ld_stride;
   logic                       w_ld_filter_size;
   logic                       w_clear_sum;
   logic                       w_put;
   logic                       w_next_filter;
   logic                       w_next_row;
   logic                       w_store_buffer;
   logic                       w_done;

   // Operand pair is consumable only when both sides are present
   assign w_issue      = av_data & av_filter;
   // Compare in the counter width so num_rows = all-ones never wraps
   assign w_last_row   = (r_row_cnt == (r_num_rows - ROW_CNT_WIDTH'(1)));
   assign w_drain_last = (r_drain_cnt == DRAIN_CNT_WIDTH'(PIPE_DEPTH - 1));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode
   always_comb begin
      w_state_nxt      = r_state;
      w_capture        = 1'b0;
      w_row_inc        = 1'b0;
      w_drain_clr      = 1'b0;
      w_drain_inc      = 1'b0;
      w_ld_stride      = 1'b0;
      w_ld_filter_size = 1'b0;
      w_clear_sum      = 1'b0;
      w_put            = 1'b0;
      w_next_filter    = 1'b0;
      w_next_row       = 1'b0;
      w_store_buffer   = 1'b0;
      w_done           = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_capture   = 1'b1;
               w_state_nxt = S_LOAD_CFG;
            end
         end

         S_LOAD_CFG: begin
            w_ld_stride      = 1'b1;
            w_ld_filter_size = 1'b1;
            w_clear_sum      = 1'b1;
            w_state_nxt      = (r_num_rows == '0) ? S_DONE : S_COMPUTE;
         end

         S_COMPUTE: begin
            // Reads go out in the same cycle operands are seen; flags only
            // mean something on an issuing cycle
            w_put = w_issue;
            if (w_issue && co_filter) begin
               w_state_nxt = end_of_row ? S_NEXT_ROW : S_NEXT_FILT;
            end
         end

         S_NEXT_FILT: begin
            w_next_filter  = 1'b1;
            w_store_buffer = 1'b1;
            w_state_nxt    = S_COMPUTE;
         end

         S_NEXT_ROW: begin
            w_next_row     = 1'b1;
            w_next_filter  = 1'b1;
            w_store_buffer = 1'b1;
            if (w_last_row) begin
               w_drain_clr = 1'b1;
               w_state_nxt = S_DRAIN;
            end else begin
               w_row_inc   = 1'b1;
               w_state_nxt = S_COMPUTE;
            end
         end

         S_DRAIN: begin
            w_drain_inc = 1'b1;
            if (w_drain_last) begin
               w_state_nxt = S_DONE;
            end
         end

         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Job configuration capture and row progress
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_num_rows <= '0;
         r_row_cnt  <= '0;
      end else if (w_capture) begin
         r_num_rows <= num_rows;
         r_row_cnt  <= '0;
      end else if (w_row_inc) begin
         r_row_cnt  <= r_row_cnt + ROW_CNT_WIDTH'(1);
      end
   end

   // Pipeline drain counter, restarted on entry to DRAIN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_drain_cnt <= '0;
      end else if (w_drain_clr) begin
         r_drain_cnt <= '0;
      end else if (w_drain_inc) begin
         r_drain_cnt <= r_drain_cnt + DRAIN_CNT_WIDTH'(1);
      end
   end

`ifdef PE_SEQ_STALL_CNT_EN
   logic [STALL_CNT_WIDTH-1:0] r_stall_cycles;
   logic                       w_stall;

   assign w_stall = (r_state == S_COMPUTE) && !w_issue;

   // Saturating count of COMPUTE cycles lost to missing operands
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cycles <= '0;
      end else if (w_capture) begin
         r_stall_cycles <= '0;
      end else if (w_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + STALL_CNT_WIDTH'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = STALL_CNT_WIDTH'(0);
`endif

   // Control outputs decode straight from state so async reset clears them
   assign ld_stride     = w_ld_stride;
   assign ld_filterSize = w_ld_filter_size;
   assign clear_sum     = w_clear_sum;
   assign put_data      = w_put;
   assign put_filter    = w_put;
   assign next_filter   = w_next_filter;
   assign next_row      = w_next_row;
   assign store_buffer  = w_store_buffer;
   assign done          = w_done;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer; one linear stimulus sequence.
module tb_pe_sequencer;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [7:0]  num_rows;
   logic        av_data;
   logic        av_filter;
   logic        co_filter;
   logic        end_of_row;
   logic        ld_stride;
   logic        ld_filterSize;
   logic        clear_sum;
   logic        put_data;
   logic        put_filter;
   logic        next_filter;
   logic        next_row;
   logic        store_buffer;
   logic        busy;
   logic        done;
   logic [15:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int cnt_nf, cnt_nr, cnt_sb, cnt_done, cnt_clr, cnt_put;

   // {ld_stride, ld_filterSize, clear_sum, put_data, put_filter,
   //  next_filter, next_row, store_buffer, busy, done}
   localparam logic [9:0] E_IDLE  = 10'b00000_00000;
   localparam logic [9:0] E_LOAD  = 10'b11100_00010;
   localparam logic [9:0] E_ISSUE = 10'b00011_00010;
   localparam logic [9:0] E_BUSY  = 10'b00000_00010;
   localparam logic [9:0] E_NFILT = 10'b00000_10110;
   localparam logic [9:0] E_NROW  = 10'b00000_11110;
   localparam logic [9:0] E_DONE  = 10'b00000_00011;

`ifdef PE_SEQ_STALL_CNT_EN
   localparam logic [15:0] STALL_EXP = 16'd5;
`else
   localparam logic [15:0] STALL_EXP = 16'd0;
`endif

   logic [9:0] outs;
   assign outs = {ld_stride, ld_filterSize, clear_sum, put_data, put_filter,
                  next_filter, next_row, store_buffer, busy, done};

   pe_sequencer dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .num_rows      (num_rows),
      .av_data       (av_data),
      .av_filter     (av_filter),
      .co_filter     (co_filter),
      .end_of_row    (end_of_row),
      .ld_stride     (ld_stride),
      .ld_filterSize (ld_filterSize),
      .clear_sum     (clear_sum),
      .put_data      (put_data),
      .put_filter    (put_filter),
      .next_filter   (next_filter),
      .next_row      (next_row),
      .store_buffer  (store_buffer),
      .busy          (busy),
      .done          (done),
      .stall_cycles  (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs after the edge, then check outputs of that cycle
   task automatic tick(input logic st, input logic avd, input logic avf,
                       input logic co, input logic eor,
                       input logic [9:0] e, input string tag);
      @(posedge clk);
      #1;
      start      = st;
      av_data    = avd;
      av_filter  = avf;
      co_filter  = co;
      end_of_row = eor;
      #1;
      chk(tag, 32'(outs), 32'(e));
      cnt_nf   += 32'(next_filter);
      cnt_nr   += 32'(next_row);
      cnt_sb   += 32'(store_buffer);
      cnt_done += 32'(done);
      cnt_clr  += 32'(clear_sum);
      cnt_put  += 32'(put_data | put_filter);
   endtask

   task automatic clr_counts();
      cnt_nf = 0; cnt_nr = 0; cnt_sb = 0; cnt_done = 0; cnt_clr = 0; cnt_put = 0;
   endtask

   // Last-row bookkeeping, drain, done, back to idle
   task automatic tail(input string tag);
      tick(0, 0, 0, 0, 0, E_NROW, {tag, "_nrow"});
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, E_BUSY, {tag, "_drain"});
      tick(0, 0, 0, 0, 0, E_DONE, {tag, "_done"});
      tick(0, 0, 0, 0, 0, E_IDLE, {tag, "_idle"});
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; num_rows = 8'd0;
      av_data = 1'b0; av_filter = 1'b0; co_filter = 1'b0; end_of_row = 1'b0;
      clr_counts();
      #2;
      chk("reset_outs", 32'(outs), 32'(E_IDLE));
      chk("reset_stall", 32'(stall_cycles), 32'd0);
      #10 rstn = 1'b1;

      // Single row, three issues, start-to-done in 9 cycles
      num_rows = 8'd1;
      tick(1, 0, 0, 0, 0, E_IDLE, "a_start");
      tick(0, 1, 1, 0, 0, E_LOAD, "a_load");
      tick(0, 1, 1, 0, 0, E_ISSUE, "a_iss0");
      tick(0, 1, 1, 0, 0, E_ISSUE, "a_iss1");
      tick(0, 1, 1, 1, 1, E_ISSUE, "a_iss2");
      tail("a");

      // Two rows of two windows, two issues per window
      clr_counts();
      num_rows = 8'd2;
      tick(1, 0, 0, 0, 0, E_IDLE, "b_start");
      tick(0, 1, 1, 0, 0, E_LOAD, "b_load");
      for (int r = 0; r < 2; r++) begin
         for (int w = 0; w < 2; w++) begin
            tick(0, 1, 1, 0, 0, E_ISSUE, "b_iss_a");
            tick(0, 1, 1, 1, (w == 1), E_ISSUE, "b_iss_b");
            if (w == 1 && r == 1) begin
               tail("b");
            end else begin
               tick(0, 1, 1, 0, 0, (w == 1) ? E_NROW : E_NFILT, "b_book");
            end
         end
      end
      chk("b_nf_total", cnt_nf, 32'd4);
      chk("b_nr_total", cnt_nr, 32'd2);
      chk("b_sb_total", cnt_sb, 32'd4);
      chk("b_done_total", cnt_done, 32'd1);
      chk("b_put_total", cnt_put, 32'd8);

      // Five stall cycles mid-window; flags during stalls must be ignored
      num_rows = 8'd1;
      tick(1, 0, 0, 0, 0, E_IDLE, "c_start");
      tick(0, 1, 1, 0, 0, E_LOAD, "c_load");
      tick(0, 1, 1, 0, 0, E_ISSUE, "c_iss0");
      for (int i = 0; i < 5; i++) tick(0, 1, 0, 1, 1, E_BUSY, "c_stall");
      tick(0, 1, 1, 1, 1, E_ISSUE, "c_iss1");
      tail("c");
      chk("c_stall_cnt", 32'(stall_cycles), 32'(STALL_EXP));
      tick(0, 0, 0, 0, 0, E_IDLE, "c_idle2");
      chk("c_stall_hold", 32'(stall_cycles), 32'(STALL_EXP));

      // Zero rows: config load then done immediately, never any reads
      clr_counts();
      num_rows = 8'd0;
      tick(1, 1, 1, 1, 1, E_IDLE, "d_start");
      tick(0, 1, 1, 1, 1, E_LOAD, "d_load");
      chk("d_stall_clr", 32'(stall_cycles), 32'd0);
      tick(0, 1, 1, 1, 1, E_DONE, "d_done");
      tick(0, 1, 1, 1, 1, E_IDLE, "d_idle");
      chk("d_put_total", cnt_put, 32'd0);

      // start held high: one run per job, next job right after IDLE
      clr_counts();
      num_rows = 8'd1;
      tick(1, 1, 1, 1, 1, E_IDLE, "e_start");
      tick(1, 1, 1, 1, 1, E_LOAD, "e_load1");
      tick(1, 1, 1, 1, 1, E_ISSUE, "e_iss1");
      tick(1, 1, 1, 1, 1, E_NROW, "e_nrow1");
      for (int i = 0; i < 3; i++) tick(1, 1, 1, 1, 1, E_BUSY, "e_drain1");
      tick(1, 1, 1, 1, 1, E_DONE, "e_done1");
      tick(1, 1, 1, 1, 1, E_IDLE, "e_idle1");
      tick(0, 1, 1, 1, 1, E_LOAD, "e_load2");
      tick(0, 1, 1, 1, 1, E_ISSUE, "e_iss2");
      tail("e");
      chk("e_clr_total", cnt_clr, 32'd2);
      chk("e_done_total", cnt_done, 32'd2);

      // Async reset while issuing
      num_rows = 8'd1;
      tick(1, 0, 0, 0, 0, E_IDLE, "f_start");
      tick(0, 1, 1, 0, 0, E_LOAD, "f_load");
      tick(0, 1, 1, 0, 0, E_ISSUE, "f_iss");
      #1 rstn = 1'b0;
      #1;
      chk("f_rst_outs", 32'(outs), 32'(E_IDLE));
      chk("f_rst_busy", 32'(busy), 32'd0);
      #1 rstn = 1'b1;
      tick(1, 1, 1, 0, 0, E_IDLE, "f_idle");
      tick(0, 1, 1, 0, 0, E_LOAD, "f_reload");
      tick(0, 1, 1, 1, 1, E_ISSUE, "f_iss2");
      tail("f");

      // Maximum row count must not wrap the row counter
      clr_counts();
      num_rows = 8'd255;
      tick(1, 0, 0, 0, 0, E_IDLE, "g_start");
      tick(0, 1, 1, 0, 0, E_LOAD, "g_load");
      for (int r = 0; r < 254; r++) begin
         tick(0, 1, 1, 1, 1, E_ISSUE, "g_iss");
         tick(0, 1, 1, 1, 1, E_NROW, "g_nrow");
      end
      tick(0, 1, 1, 1, 1, E_ISSUE, "g_iss_last");
      tail("g");
      chk("g_nr_total", cnt_nr, 32'd255);
      chk("g_done_total", cnt_done, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
